systolic_skew_feeder: RTL

//  Tile-level input stage for the systolic array edge. Accepts one LANES-wide row vector per

---
 rtl/systolic_pkg.sv | 17 +
 rtl/VX_shift_register.sv | 35 +++
 rtl/systolic_skew_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array input feeder.
package systolic_pkg;

    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_DATAW = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feeder_state_e;

    function automatic int unsigned cnt_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/VX_shift_register.sv
// Enabled delay line of DEPTH stages; only the top RESETW bits of each stage are reset.
module VX_shift_register #(
    parameter int unsigned DATAW  = 1,
    parameter int unsigned RESETW = 1,
    parameter int unsigned DEPTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [DATAW-1:0] q;
        logic [DATAW-1:0] d;

        if (g == 0) begin : g_first
            assign d = data_in;
        end else begin : g_next
            assign d = g_stage[g-1].q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                q[DATAW-1 -: RESETW] <= '0;
            end else if (enable) begin
                q <= d;
            end
        end
    end

    assign data_out = g_stage[DEPTH-1].q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Re-times LANES-wide rows into a diagonal wavefront (lane i delayed i cycles) and
// drains the skew after the last row of a tile before pulsing tile_done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned DATAW = DEF_DATAW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [LANES*DATAW-1:0] in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic                   array_stall,
    output logic                   out_enable,
    output logic [LANES*DATAW-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    output logic                   tile_done,
    output logic                   busy
);

    localparam int unsigned     CNTW     = cnt_width(LANES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((LANES > 1) ? LANES - 2 : 0);

    feeder_state_e          state, state_next;
    logic [CNTW-1:0]        drain_cnt, drain_cnt_next;
    logic                   done_reg, done_next;
    logic                   enable;
    logic                   fire;
    logic [LANES*DATAW-1:0] row_gated;
    logic [LANES-1:0]       stage_valid;
    logic [LANES*DATAW-1:0] stage_data;
    logic [LANES*DATAW-1:0] lane_out;

    assign enable     = ~array_stall;
    assign in_ready   = ~reset & enable & (state != DRAIN);
    assign fire       = in_valid & in_ready;
    assign out_enable = enable;
    assign busy       = (state != IDLE);
    // done_reg holds through a stall, so the pulse lands on the first released cycle
    assign tile_done  = done_reg & enable;
    assign row_gated  = fire ? in_data : '0;

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        done_next      = 1'b0;
        unique case (state)
            IDLE, STREAM: begin
                if (fire) begin
                    if (!in_last) begin
                        state_next = STREAM;
                    end else if (LANES > 1) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == CNT_LAST) begin
                    state_next     = IDLE;
                    drain_cnt_next = '0;
                    done_next      = 1'b1;
                end else begin
                    drain_cnt_next = drain_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_reg  <= 1'b0;
        end else if (enable) begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            done_reg  <= done_next;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign stage_valid[0]       = fire;
            assign stage_data[0 +: DATAW] = row_gated[0 +: DATAW];
        end else begin : g_skew
            logic [DATAW:0] sr_out;

            VX_shift_register #(
                .DATAW  (DATAW + 1),
                .RESETW (1),
                .DEPTH  (i)
            ) u_delay (
                .clk      (clk),
                .reset    (reset),
                .enable   (enable),
                .data_in  ({fire, row_gated[i*DATAW +: DATAW]}),
                .data_out (sr_out)
            );

            assign stage_valid[i]             = sr_out[DATAW];
            assign stage_data[i*DATAW +: DATAW] = sr_out[DATAW-1:0];
        end
        // delay-line data bits are not reset, so gate them with their valid
        assign lane_out[i*DATAW +: DATAW] = {DATAW{stage_valid[i]}} & stage_data[i*DATAW +: DATAW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
        end else if (enable) begin
            out_valid <= stage_valid;
            out_data  <= lane_out;
        end
    end

endmodule
